eq_stream_checker: RTL

Parametrised equivalence-check harness controller that co-simulates a specification model and an implementation under formal or simulation checking. It generates per-design step enables with a bounded-run cycle counter and a completion drain window. It sinks each design's output stream into its own FIFO and compares the two streams token by token in order. It reports the first mismatch, length mismatch, timeout and done status to the property layer.

---
 rtl/eq_stream_checker.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/eq_stream_checker.sv
// Equivalence-check harness controller: steps a spec model and an implementation,
// buffers both output streams and compares them token by token in order.
module eq_stream_checker #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 5,
    parameter int BOUND        = 35,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ila_complete,
    input  logic              hls_complete,
    input  logic [DATA_W-1:0] ila_TDATA,
    input  logic              ila_TVALID,
    output logic              ila_TREADY,
    input  logic [DATA_W-1:0] hls_TDATA,
    input  logic              hls_TVALID,
    output logic              hls_TREADY,
    output logic              ila_step,
    output logic              hls_step,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  tok_cnt,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mismatch_idx,
    output logic              len_err,
    output logic              timeout,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FC_W  = PTR_W + 1;
    localparam logic [FC_W-1:0]  L_DEPTH    = FC_W'(DEPTH);
    localparam logic [CNT_W-1:0] L_DRAIN    = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] L_WAIT_MAX = CNT_W'(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] L_BOUND    = CNT_W'(BOUND);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_tok_cnt;
    logic [CNT_W-1:0]  r_mismatch_idx;
    logic [CNT_W-1:0]  r_hls_wait;
    logic              r_mismatch;
    logic              r_len_err;
    logic              r_timeout;
    logic              r_done;
    logic              r_ila_seen;

    logic [DATA_W-1:0] r_ila_mem [DEPTH];
    logic [DATA_W-1:0] r_hls_mem [DEPTH];
    logic [PTR_W-1:0]  r_ila_wp, r_ila_rp, r_hls_wp, r_hls_rp;
    logic [FC_W-1:0]   r_ila_cnt, r_hls_cnt;

    logic              w_run, w_drain, w_restart;
    logic              w_ila_empty, w_hls_empty;
    logic              w_ila_push, w_hls_push, w_pop;
    logic [DATA_W-1:0] w_ila_head, w_hls_head;

    assign w_run       = (r_state == S_RUN);
    assign w_drain     = (r_state == S_DRAIN);
    assign w_restart   = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_ila_empty = (r_ila_cnt == {FC_W{1'b0}});
    assign w_hls_empty = (r_hls_cnt == {FC_W{1'b0}});
    assign ila_TREADY  = w_run & (r_ila_cnt < L_DEPTH);
    assign hls_TREADY  = w_run & (r_hls_cnt < L_DEPTH);
    assign w_ila_push  = ila_TVALID & ila_TREADY;
    assign w_hls_push  = hls_TVALID & hls_TREADY;
    assign w_pop       = (w_run | w_drain) & ~w_ila_empty & ~w_hls_empty;
    assign w_ila_head  = r_ila_mem[r_ila_rp];
    assign w_hls_head  = r_hls_mem[r_hls_rp];

    // ila_step reacts to ila_complete in the same cycle; hls_step lags on the registered wait count
    assign ila_step     = w_run & ~ila_complete & ~r_ila_seen;
    assign hls_step     = w_run & (r_hls_wait <= L_DRAIN);
    assign state        = r_state;
    assign cycle_cnt    = r_cycle_cnt;
    assign tok_cnt      = r_tok_cnt;
    assign mismatch     = r_mismatch;
    assign mismatch_idx = r_mismatch_idx;
    assign len_err      = r_len_err;
    assign timeout      = r_timeout;
    assign done         = r_done;

    // Run-control FSM: step bookkeeping, bound counter and completion flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cycle_cnt <= {CNT_W{1'b0}};
            r_hls_wait  <= {CNT_W{1'b0}};
            r_ila_seen  <= 1'b0;
            r_len_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_cycle_cnt <= {CNT_W{1'b0}};
                        r_hls_wait  <= {CNT_W{1'b0}};
                        r_ila_seen  <= 1'b0;
                        r_len_err   <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_done      <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_RUN: begin
                    r_ila_seen <= r_ila_seen | ila_complete;
                    if (!hls_complete) begin
                        r_hls_wait <= {CNT_W{1'b0}};
                    end else if (r_hls_wait < L_WAIT_MAX) begin
                        r_hls_wait <= r_hls_wait + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_hls_wait <= r_hls_wait;
                    end
                    if (r_cycle_cnt < L_BOUND) begin
                        r_cycle_cnt <= r_cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_cycle_cnt <= r_cycle_cnt;
                    end
                    // The bound check wins over a completion seen in the same cycle
                    if (r_cycle_cnt == L_BOUND) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end else if (r_ila_seen && (r_hls_wait > L_DRAIN)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (w_ila_empty || w_hls_empty) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_len_err <= ~(w_ila_empty & w_hls_empty);
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pairwise compare: counts popped pairs and latches the first differing index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tok_cnt      <= {CNT_W{1'b0}};
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= {CNT_W{1'b0}};
        end else if (w_restart) begin
            r_tok_cnt      <= {CNT_W{1'b0}};
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= {CNT_W{1'b0}};
        end else if (w_pop) begin
            r_tok_cnt <= r_tok_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if ((w_ila_head != w_hls_head) && !r_mismatch) begin
                r_mismatch     <= 1'b1;
                r_mismatch_idx <= r_tok_cnt;
            end else begin
                r_mismatch     <= r_mismatch;
                r_mismatch_idx <= r_mismatch_idx;
            end
        end else begin
            r_tok_cnt <= r_tok_cnt;
        end
    end

    // Spec-side FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ila_wp  <= {PTR_W{1'b0}};
            r_ila_rp  <= {PTR_W{1'b0}};
            r_ila_cnt <= {FC_W{1'b0}};
        end else if (w_restart) begin
            r_ila_wp  <= {PTR_W{1'b0}};
            r_ila_rp  <= {PTR_W{1'b0}};
            r_ila_cnt <= {FC_W{1'b0}};
        end else begin
            if (w_ila_push) r_ila_wp <= r_ila_wp + PTR_W'(1);
            else            r_ila_wp <= r_ila_wp;
            if (w_pop)      r_ila_rp <= r_ila_rp + PTR_W'(1);
            else            r_ila_rp <= r_ila_rp;
            case ({w_ila_push, w_pop})
                2'b10:   r_ila_cnt <= r_ila_cnt + FC_W'(1);
                2'b01:   r_ila_cnt <= r_ila_cnt - FC_W'(1);
                default: r_ila_cnt <= r_ila_cnt;
            endcase
        end
    end

    // Implementation-side FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hls_wp  <= {PTR_W{1'b0}};
            r_hls_rp  <= {PTR_W{1'b0}};
            r_hls_cnt <= {FC_W{1'b0}};
        end else if (w_restart) begin
            r_hls_wp  <= {PTR_W{1'b0}};
            r_hls_rp  <= {PTR_W{1'b0}};
            r_hls_cnt <= {FC_W{1'b0}};
        end else begin
            if (w_hls_push) r_hls_wp <= r_hls_wp + PTR_W'(1);
            else            r_hls_wp <= r_hls_wp;
            if (w_pop)      r_hls_rp <= r_hls_rp + PTR_W'(1);
            else            r_hls_rp <= r_hls_rp;
            case ({w_hls_push, w_pop})
                2'b10:   r_hls_cnt <= r_hls_cnt + FC_W'(1);
                2'b01:   r_hls_cnt <= r_hls_cnt - FC_W'(1);
                default: r_hls_cnt <= r_hls_cnt;
            endcase
        end
    end

    // Token storage; occupancy is tracked by the pointer blocks
    always_ff @(posedge clk) begin
        if (w_ila_push) r_ila_mem[r_ila_wp] <= ila_TDATA;
        if (w_hls_push) r_hls_mem[r_hls_wp] <= hls_TDATA;
    end

endmodule
